int_result_bcd: RTL and testbench
=================================

INT_RESULT_BCD -- requirements
Module: int_result_bcd

Interface
REQ-001 SHALL have parameter W, default 64, meaning the binary operand width; only 64 is supported.
REQ-002 SHALL have parameter D, default 20, meaning the BCD digit count, sufficient for 2^64-1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning a result word is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the block can accept a word.
REQ-007 SHALL have port bin_in, input, 64, the calculator result word.
REQ-008 SHALL have port is_signed, input, 1, meaning bin_in is treated as two's complement; sampled with bin_in.
REQ-009 SHALL have port out_valid, output, 1, meaning the BCD result is available.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 SHALL have port bcd_out, output, 80, holding 20 packed BCD digits; digit 0 (least significant) is in bits [3:0].
REQ-012 SHALL have port neg, output, 1, the sign of the converted value.
REQ-013 SHALL have port ndigits, output, 5, the count of significant digits (1..20).

Function
REQ-014 SHALL implement states IDLE, SHIFT and DONE.
REQ-015 SHALL drive in_ready high only in IDLE and out_valid high only in DONE.
REQ-016 SHALL accept a word at a rising edge where state=IDLE and in_valid=1, then go to SHIFT.
REQ-017 SHALL, at acceptance, load a magnitude register with -bin_in and set neg=1 when is_signed=1 and bin_in[63]=1.
REQ-018 SHALL, at acceptance in all other cases, load the magnitude register with bin_in and set neg=0.
REQ-019 SHALL, at acceptance, clear the BCD accumulator and load a 7-bit shift counter with 0.
REQ-020 SHALL, on each SHIFT edge, add 3 to every accumulator digit that is >=5, then shift {accumulator, magnitude} left by one bit, then increment the counter.
REQ-021 SHALL transition SHIFT->DONE on the edge performing the 64th shift.
REQ-022 SHALL therefore assert out_valid exactly 64 clock cycles after the accept edge; the block is not pipelined and holds one conversion at a time.
REQ-023 SHALL hold bcd_out, neg and ndigits stable while out_valid=1.
REQ-024 SHALL transition DONE->IDLE on an edge where out_ready=1.
REQ-025 SHALL not accept a new word on the same edge as the DONE->IDLE transition (minimum of one IDLE cycle).
REQ-026 SHALL ignore in_valid in SHIFT and DONE; bin_in and is_signed are don't-care outside the accept edge.
REQ-027 SHALL ignore out_ready outside DONE.
REQ-028 SHALL derive ndigits combinationally from bcd_out as the index of the highest nonzero digit plus 1, and as 1 when the value is zero.
REQ-029 SHALL convert signed 0x8000000000000000 to magnitude 9223372036854775808 with neg=1; this conversion has no overflow.
REQ-030 SHALL never produce an accumulator digit >9 after the final shift.

Reset
REQ-031 SHALL, while rst_n=0, immediately force state=IDLE, in_ready=1, out_valid=0, bcd_out=0, neg=0 and counter=0, regardless of clk.
REQ-032 SHALL abandon any in-flight conversion when reset is asserted in SHIFT or DONE, and produce no out_valid afterwards for that word.
REQ-033 SHALL, after rst_n deasserts, accept a word no earlier than the first rising edge at which rst_n is sampled high.
REQ-034 SHALL drive ndigits=1 during reset, as a consequence of bcd_out=0.

Verification
REQ-035 SHALL verify: bin_in=0xFFFFFFFFFFFFFFFF, is_signed=0 -> bcd_out digits 18446744073709551615, neg=0, ndigits=20, out_valid at accept+64.
REQ-036 SHALL verify: bin_in=0xFFFFFFFFFFFFFFF9 (-7), is_signed=1 -> bcd_out=7, neg=1, ndigits=1.
REQ-037 SHALL verify: bin_in=0x8000000000000000, is_signed=1 -> bcd_out digits 9223372036854775808, neg=1, ndigits=19.
REQ-038 SHALL verify: bin_in=0, is_signed=1 -> bcd_out=0, neg=0, ndigits=1.
REQ-039 SHALL verify: bin_in=12345 with out_ready held low 10 cycles in DONE -> outputs stable; in_valid pulses ignored; IDLE one cycle after out_ready=1.
REQ-040 SHALL verify: rst_n pulsed low at shift 30 of a conversion -> outputs zero asynchronously, no out_valid afterwards; next word 99 converts correctly in 64 cycles.

Source files
------------

// File: rtl/int_result_bcd.sv
// Binary-to-BCD converter for the calculator result word: sign/magnitude split,
// then a serial shift-and-add-3 conversion, one bit per clock.
module int_result_bcd #(
    parameter int W = 64,
    parameter int D = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     bin_in,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4*D-1:0]   bcd_out,
    output logic             neg,
    output logic [4:0]       ndigits
);

    // state | meaning
    // IDLE  | waiting for a word, in_ready high
    // SHIFT | one double-dabble step per clock, 64 in total
    // DONE  | result held, out_valid high until out_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [W-1:0]     r_mag;
    logic [4*D-1:0]   r_bcd;
    logic             r_neg;
    logic [6:0]       r_cnt;
    logic [4*D-1:0]   w_adj;
    logic             w_last;

    assign w_last = (r_cnt == 7'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = SHIFT;
            end
            SHIFT: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Digits >= 5 are pre-corrected so the following left shift carries into the next digit.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < D; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag <= '0;
            r_bcd <= '0;
            r_neg <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_signed && bin_in[W-1]) begin
                            r_mag <= -bin_in;
                            r_neg <= 1'b1;
                        end else begin
                            r_mag <= bin_in;
                            r_neg <= 1'b0;
                        end
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_bcd <= {w_adj[4*D-2:0], r_mag[W-1]};
                    r_mag <= {r_mag[W-2:0], 1'b0};
                    r_cnt <= r_cnt + 7'd1;
                end
                default: ;
            endcase
        end
    end

    assign bcd_out = r_bcd;
    assign neg     = r_neg;

    always_comb begin
        ndigits = 5'd1;
        for (int i = 1; i < D; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) ndigits = 5'(i + 1);
        end
    end

endmodule

// File: tb/tb_int_result_bcd.sv
// Bench for int_result_bcd: fixed vector table, random words against an
// arithmetic model, and hand-written hold/reset sequences.
module tb_int_result_bcd;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] bin_in;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [79:0] bcd_out;
    logic        neg;
    logic [4:0]  ndigits;

    int n_chk  = 0;
    int n_fail = 0;

    int_result_bcd #(.W(64), .D(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .neg       (neg),
        .ndigits   (ndigits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] bin;
        logic        sgn;
        logic [79:0] bcd;
        logic        neg;
        logic [4:0]  nd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: sign/magnitude by two's complement arithmetic, digits by repeated /10.
    task automatic model(input logic [63:0] b, input logic s,
                         output logic [79:0] bcd, output logic n, output logic [4:0] nd);
        logic [63:0] mag;
        n   = s && b[63];
        mag = n ? (~b + 64'd1) : b;
        bcd = '0;
        nd  = 5'd1;
        for (int i = 0; i < 20; i++) begin
            bcd[4*i +: 4] = 4'(mag % 64'd10);
            mag = mag / 64'd10;
            if (bcd[4*i +: 4] != 4'd0) nd = 5'(i + 1);
        end
    endtask

    task automatic start(input logic [63:0] b, input logic s);
        @(negedge clk);
        bin_in    = b;
        is_signed = s;
        in_valid  = 1'b1;
        chk("in_ready_before_accept", {79'd0, in_ready}, 80'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        bin_in    = {$urandom, $urandom};
        is_signed = 1'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_result(input string name, input int cyc,
                                input logic [79:0] eb, input logic en, input logic [4:0] end_);
        chk({name, "_latency"}, 80'(cyc), 80'd64);
        chk({name, "_bcd"}, bcd_out, eb);
        chk({name, "_neg"}, {79'd0, neg}, {79'd0, en});
        chk({name, "_ndigits"}, {75'd0, ndigits}, {75'd0, end_});
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_out_valid", {79'd0, out_valid}, 80'd0);
        chk("release_in_ready", {79'd0, in_ready}, 80'd1);
    endtask

    initial begin
        int          cyc;
        int          seen_valid;
        logic [79:0] eb;
        logic        en;
        logic [4:0]  end_;
        logic [63:0] rb;
        logic        rs;
        logic [79:0] held;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 80'h18446744073709551615, 1'b0, 5'd20};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 80'h7, 1'b1, 5'd1};
        vecs[2] = '{64'h8000_0000_0000_0000, 1'b1, 80'h09223372036854775808, 1'b1, 5'd19};
        vecs[3] = '{64'h0, 1'b1, 80'h0, 1'b0, 5'd1};
        vecs[4] = '{64'h8000_0000_0000_0000, 1'b0, 80'h09223372036854775808, 1'b0, 5'd19};
        vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 80'h09223372036854775807, 1'b0, 5'd19};
        vecs[6] = '{64'd10, 1'b0, 80'h10, 1'b0, 5'd2};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 80'h1, 1'b1, 5'd1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        bin_in    = '0;
        is_signed = 1'b0;
        out_ready = 1'b0;
        #22;
        chk("reset_in_ready", {79'd0, in_ready}, 80'd1);
        chk("reset_out_valid", {79'd0, out_valid}, 80'd0);
        chk("reset_bcd", bcd_out, 80'd0);
        chk("reset_neg", {79'd0, neg}, 80'd0);
        chk("reset_ndigits", {75'd0, ndigits}, 80'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            start(vecs[i].bin, vecs[i].sgn);
            wait_done(cyc);
            check_result($sformatf("vec%0d", i), cyc, vecs[i].bcd, vecs[i].neg, vecs[i].nd);
            release_out();
        end

        for (int i = 0; i < 20; i++) begin
            rb = {$urandom, $urandom};
            if (i % 3 == 1) rb = rb >> $urandom_range(63, 1);
            rs = 1'($urandom);
            model(rb, rs, eb, en, end_);
            start(rb, rs);
            wait_done(cyc);
            check_result($sformatf("rand%0d", i), cyc, eb, en, end_);
            release_out();
        end

        // Held result: out_ready low for 10 cycles while in_valid toggles
        start(64'd12345, 1'b0);
        wait_done(cyc);
        check_result("hold", cyc, 80'h12345, 1'b0, 5'd5);
        held = bcd_out;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid  = ~in_valid;
            bin_in    = {$urandom, $urandom};
            is_signed = 1'($urandom);
            @(posedge clk);
            #1;
            chk("hold_out_valid", {79'd0, out_valid}, 80'd1);
            chk("hold_in_ready", {79'd0, in_ready}, 80'd0);
            chk("hold_bcd", bcd_out, held);
            chk("hold_neg_nd", {74'd0, neg, ndigits}, {74'd0, 1'b0, 5'd5});
        end
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("done_to_idle_in_ready", {79'd0, in_ready}, 80'd1);
        chk("done_to_idle_out_valid", {79'd0, out_valid}, 80'd0);
        @(posedge clk);
        #1;
        chk("no_accept_on_exit", {79'd0, in_ready}, 80'd1);

        // Reset in the middle of a conversion
        start(64'h8000_0000_0000_0000, 1'b1);
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {79'd0, out_valid}, 80'd0);
        chk("midreset_in_ready", {79'd0, in_ready}, 80'd1);
        chk("midreset_bcd", bcd_out, 80'd0);
        chk("midreset_neg", {79'd0, neg}, 80'd0);
        chk("midreset_ndigits", {75'd0, ndigits}, 80'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid++;
        end
        chk("midreset_no_valid", 80'(seen_valid), 80'd0);
        start(64'd99, 1'b0);
        wait_done(cyc);
        check_result("after_reset", cyc, 80'h99, 1'b0, 5'd2);
        release_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
